// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch/decode/imem/redirect bundle for fetch_sequencer
//
// Purpose: groups every non-clock signal of the fetch sequencer.
// Ports (master = fetch_sequencer side):
//   imem_addr      out  byte address to instruction memory (current PC)
//   imem_instr     in   instruction word for imem_addr (combinational)
//   out_valid      out  head queue entry valid
//   out_ready      in   decode accepts head entry
//   out_instr      out  head entry instruction word
//   out_pc         out  head entry byte PC
//   redirect_valid in   one-cycle fetch restart request
//   redirect_pc    in   restart byte address (bits [1:0] ignored)
//   fetch_fault    out  FAULT state with empty queue
//   queue_count    out  occupied queue entries (0..2)

interface fetch_sequencer_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] imem_addr;
  logic [WORD_SIZE-1:0] imem_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_instr;
  logic [WORD_SIZE-1:0] out_pc;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 fetch_fault;
  logic [1:0]           queue_count;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_fault,
    output queue_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc,
    input  fetch_fault,
    input  queue_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with 2-entry output queue
//
// Purpose: owns the PC, fetches from a combinational instruction memory,
// buffers {instr, pc} pairs in a 2-entry FIFO for decode, handles redirects
// and parks in FAULT when the PC walks past the end of memory.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    fetch_sequencer_if.master (see interface file for signal list)

module fetch_sequencer #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   MEM_DEPTH = 25,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_sequencer_if.master   bus
);

  localparam int IDXW = WORD_SIZE - 2;
  localparam logic [IDXW-1:0] DEPTH_IDX = IDXW'(MEM_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] pc, pc_nxt;
  logic [1:0]           count, count_nxt;

  // Queue storage: head is always slot 0 so outputs come straight from flops.
  logic [WORD_SIZE-1:0] head_instr, head_pc;
  logic [WORD_SIZE-1:0] tail_instr, tail_pc;

  logic                 in_range;
  logic                 pop;
  logic                 enq;
  logic                 head_load_new;
  logic                 head_load_tail;
  logic                 tail_load_new;
  logic [WORD_SIZE-1:0] redirect_aligned;

  // Masking keeps every redirect_pc bit in the logic cone.
  assign redirect_aligned = bus.redirect_pc & ~WORD_SIZE'(3);

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state, fetch and queue control ----------------
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    count_nxt      = count;
    head_load_new  = 1'b0;
    head_load_tail = 1'b0;
    tail_load_new  = 1'b0;

    in_range = (pc[WORD_SIZE-1:2] < DEPTH_IDX);
    pop      = (count != 2'd0) && bus.out_ready;
    enq      = (state == ST_RUN) && in_range && !bus.redirect_valid &&
               ((count < 2'd2) || pop);

    if (bus.redirect_valid) begin
      // Redirect wins over everything; a same-cycle pop is simply lost with
      // the rest of the flushed queue, which is what decode expects.
      state_nxt = ST_RUN;
      pc_nxt    = redirect_aligned;
      count_nxt = 2'd0;
    end else begin
      if ((state == ST_RUN) && !in_range) begin
        state_nxt = ST_FAULT;
      end

      if (enq) begin
        pc_nxt = pc + WORD_SIZE'(4);
      end

      case ({pop, enq})
        2'b10:   count_nxt = count - 2'd1;
        2'b01:   count_nxt = count + 2'd1;
        default: count_nxt = count;
      endcase

      // Shift the second entry forward when the head leaves a full queue.
      if (pop && (count == 2'd2)) begin
        head_load_tail = 1'b1;
      end

      // New word lands in the head slot if the queue is (or becomes) empty
      // at the head position, otherwise behind it.
      if (enq) begin
        if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          head_load_new = 1'b1;
        end else begin
          tail_load_new = 1'b1;
        end
      end
    end
  end

  // ---------------- PC and count ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      count <= 2'd0;
    end else begin
      pc    <= pc_nxt;
      count <= count_nxt;
    end
  end

  // ---------------- queue data ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else begin
      if (head_load_new) begin
        head_instr <= bus.imem_instr;
        head_pc    <= pc;
      end else if (head_load_tail) begin
        head_instr <= tail_instr;
        head_pc    <= tail_pc;
      end
      if (tail_load_new) begin
        tail_instr <= bus.imem_instr;
        tail_pc    <= pc;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.imem_addr   = pc;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_instr   = head_instr;
  assign bus.out_pc      = head_pc;
  assign bus.fetch_fault = (state == ST_FAULT) && (count == 2'd0);
  assign bus.queue_count = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer

module tb_fetch_sequencer;

  localparam int W = 32;
  localparam int D = 25;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.WORD_SIZE(W)) bus ();

  fetch_sequencer #(
    .WORD_SIZE(W),
    .MEM_DEPTH(D),
    .RESET_PC ('0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Instruction memory: word i holds 0x1000_0000 + i, out of range reads junk.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] < 30'(D)) return 32'h1000_0000 + {2'b00, a[31:2]};
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_count", {30'd0, bus.queue_count}, 32'd0);
    check_val("rst_addr", bus.imem_addr, 32'h0);
    check_val("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    check_val("rst_out_pc", bus.out_pc, 32'h0);
    check_val("rst_out_instr", bus.out_instr, 32'h0);

    // ---- streaming with out_ready=1 ----
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val($sformatf("run_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
      check_val($sformatf("run_pc%0d", k), bus.out_pc, 32'(4 * k));
      check_val($sformatf("run_instr%0d", k), bus.out_instr, 32'h1000_0000 + 32'(k));
      check_val($sformatf("run_count%0d", k), {30'd0, bus.queue_count}, 32'd1);
    end

    // ---- back-pressure: queue fills and holds ----
    do_reset();
    tick();
    check_val("bp_count1", {30'd0, bus.queue_count}, 32'd1);
    tick();
    check_val("bp_count2", {30'd0, bus.queue_count}, 32'd2);
    tick();
    tick();
    check_val("bp_count_hold", {30'd0, bus.queue_count}, 32'd2);
    check_val("bp_addr_hold", bus.imem_addr, 32'h8);
    check_val("bp_head0", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check_val("bp_head4", bus.out_pc, 32'h4);
    check_val("bp_instr4", bus.out_instr, 32'h1000_0001);
    tick();
    check_val("bp_head8", bus.out_pc, 32'h8);
    check_val("bp_instr8", bus.out_instr, 32'h1000_0002);
    check_val("bp_count_full", {30'd0, bus.queue_count}, 32'd2);

    // ---- redirect while full and popping ----
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_000E;
    tick();
    bus.redirect_valid = 1'b0;
    check_val("rd_count", {30'd0, bus.queue_count}, 32'd0);
    check_val("rd_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rd_addr", bus.imem_addr, 32'hC);
    tick();
    check_val("rd_valid1", {31'd0, bus.out_valid}, 32'd1);
    check_val("rd_pc", bus.out_pc, 32'hC);
    check_val("rd_instr", bus.out_instr, 32'h1000_0003);
    tick();
    check_val("rd_next_pc", bus.out_pc, 32'h10);

    // ---- run off the end of memory ----
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      tick();
      check_val($sformatf("end_pc%0d", k), bus.out_pc, 32'(4 * k));
    end
    check_val("end_last_instr", bus.out_instr, 32'h1000_0018);
    check_val("end_fault_busy", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    check_val("end_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("end_fault", {31'd0, bus.fetch_fault}, 32'd1);
    check_val("end_addr", bus.imem_addr, 32'h64);
    tick();
    tick();
    check_val("end_valid_stay", {31'd0, bus.out_valid}, 32'd0);
    check_val("end_addr_stay", bus.imem_addr, 32'h64);

    // ---- recover from FAULT ----
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8;
    tick();
    bus.redirect_valid = 1'b0;
    check_val("rec_fault", {31'd0, bus.fetch_fault}, 32'd0);
    check_val("rec_valid0", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check_val("rec_valid1", {31'd0, bus.out_valid}, 32'd1);
    check_val("rec_pc", bus.out_pc, 32'h8);
    check_val("rec_instr", bus.out_instr, 32'h1000_0002);

    // ---- redirect to an out-of-range address ----
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    check_val("oor_fault0", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    check_val("oor_fault1", {31'd0, bus.fetch_fault}, 32'd1);
    check_val("oor_addr", bus.imem_addr, 32'h100);

    // ---- async reset mid-stream with a full queue ----
    do_reset();
    tick();
    tick();
    check_val("ar_full", {30'd0, bus.queue_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("ar_count", {30'd0, bus.queue_count}, 32'd0);
    check_val("ar_addr", bus.imem_addr, 32'h0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and drives the byte address of the combinational instruction memory.
- Buffers fetched words with their PCs in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution.
- Detects fetches beyond the memory depth and parks in a fault state until redirected.

Parameters:
- WORD_SIZE, 32, width of instruction words and addresses.
- MEM_DEPTH, 25, number of words in instruction memory; valid word index range is 0..MEM_DEPTH-1.
- RESET_PC, 0, byte address loaded into the PC at reset; must be word aligned.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- imem_addr  output  WORD_SIZE  byte address to instruction memory; always equals the current PC.
- imem_instr  input  WORD_SIZE  instruction word returned combinationally for imem_addr.
- out_valid  output  1  head queue entry is valid.
- out_ready  input  1  decode accepts the head entry this cycle.
- out_instr  output  WORD_SIZE  instruction word of the head entry.
- out_pc  output  WORD_SIZE  byte PC of the head entry.
- redirect_valid  input  1  one-cycle request to restart fetch.
- redirect_pc  input  WORD_SIZE  new fetch byte address; bits [1:0] are ignored (treated as 0).
- fetch_fault  output  1  set while in FAULT with an empty queue.
- queue_count  output  2  number of occupied queue entries (0..2), for debug and verification.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, queue_count=0, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, fetch_fault=0.
- imem_addr = pc, combinational from the register. Word index = pc[WORD_SIZE-1:2]. in_range = (word index < MEM_DEPTH).
- pop = out_valid && out_ready.
- enq = state==RUN && in_range && !redirect_valid && (queue_count<2 || pop).
- On enq:
  - {imem_instr, pc} is written to the tail.
  - pc <= pc+4, wrapping modulo 2^WORD_SIZE.
- Queue:
  - 2-entry FIFO; head feeds out_instr/out_pc directly from registers.
  - Pop and enq in the same cycle: count unchanged, order preserved.
  - Full (count=2) without pop: no enq, pc holds.
  - Empty: out_valid=0; out_instr/out_pc hold their last values (don't-care).
- Latency:
  - The first rising edge after reset release enqueues RESET_PC; out_valid=1 from that edge.
  - With out_ready held at 1, one instruction per cycle is delivered in PC order.
- Redirect (redirect_valid=1 at an edge):
  - Queue flushed (count<=0).
  - pc <= {redirect_pc[WORD_SIZE-1:2], 2'b00}.
  - state <= RUN, no enqueue that cycle.
  - A pop in the same cycle still counts as consumed by decode.
  - out_valid=0 in the following cycle; the first redirected instruction is valid one cycle after that.
  - Redirect has priority over every other event, including FAULT.
- States:
  - RUN: normal fetch. If !in_range and !redirect_valid, state <= FAULT; pc holds and no enqueue occurs.
  - FAULT: no fetch; queued entries still drain normally. fetch_fault = (state==FAULT && queue_count==0).
  - FAULT -> RUN only by redirect. A redirect to an out-of-range address re-enters FAULT on the next edge.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-operation: all state cleared immediately; any queued entries are discarded.

Test Plan:
- Reset release, memory words W0..W4 at indices 0..4, out_ready=1 -> out_valid=1 from first edge; out_pc sequence 0,4,8,12,16 with matching words; queue_count=1 steady.
- out_ready=0 for 4 cycles after start -> queue_count reaches 2 and holds; imem_addr holds at 8; on out_ready=1, out_pc = 0 then 4, followed by 8 with no gap or duplicate.
- Redirect to 0x0000000E while queue is full and out_ready=1 -> next cycle queue_count=0, out_valid=0; then out_pc=0x0C, instruction=mem[3]; the popped head is counted consumed.
- MEM_DEPTH=25, free-run from 0 -> last delivered out_pc=0x60 (index 24); pc stays at 0x64; fetch_fault=1 once the queue drains; no further out_valid.
- In FAULT, redirect to 0x8 -> fetch_fault=0 on the next edge; out_pc=0x8 valid one cycle later.
- Assert rst_n=0 mid-stream with queue_count=2 -> immediately out_valid=0, queue_count=0, imem_addr=RESET_PC, with no clock edge required.
